// File: rtl/mh_self_attention_ctrl_pkg.sv
// Shared types and sizing helpers for the multi-head self-attention controller.
package mh_self_attention_ctrl_pkg;

  localparam int DEF_TOTAL_SOFTMAX_ROW = 16;
  localparam int DEF_COL               = 64;
  localparam int DEF_TILE_SIZE         = 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SLICE,
    STREAM,
    DRAIN,
    REARM,
    DONE
  } sa_seq_state_e;

  // Number of softmax beats needed to cover one score row.
  function automatic int NUM_TILES_F(input int col, input int tile);
    return col / tile;
  endfunction

  // Counter width for n distinct values, never narrower than one bit.
  function automatic int CNT_W(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mh_self_attention_ctrl_sa_head_seq.sv
// One-head sequencer: walks the b2r slices of a head through the softmax bank,
// applies the causal mask per row and emits the re-arm pulses between slices.
module sa_head_seq
  import mh_self_attention_ctrl_pkg::*;
#(
  parameter int TOTAL_SOFTMAX_ROW = DEF_TOTAL_SOFTMAX_ROW,
  parameter int COL               = DEF_COL,
  parameter int TILE_SIZE         = DEF_TILE_SIZE,
  parameter int NUM_ROW_BLOCKS    = 4,
  parameter int SOFTMAX_LATENCY   = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic                         causal_en_i,
  input  logic                         softmax_ready_i,
  input  logic                         out_ready_i,
  input  logic                         slice_done_i,
  output logic                         rst_n_b2r_o,
  output logic                         rst_n_softmax_o,
  output logic                         softmax_en_o,
  output logic [TOTAL_SOFTMAX_ROW-1:0] softmax_valid_o,
  output logic                         head_done_o,
  output logic                         head_done_nxt_o
);

  localparam int NUM_TILES = NUM_TILES_F(COL, TILE_SIZE);
  localparam int TW        = CNT_W(NUM_TILES);
  localparam int BW        = CNT_W(NUM_ROW_BLOCKS);
  localparam int LW        = CNT_W(SOFTMAX_LATENCY);
  localparam int PW        = $clog2(NUM_ROW_BLOCKS * TOTAL_SOFTMAX_ROW + COL) + 1;

  localparam logic [TW-1:0] LAST_TILE = TW'(NUM_TILES - 1);
  localparam logic [BW-1:0] LAST_BLK  = BW'(NUM_ROW_BLOCKS - 1);
  localparam logic [LW-1:0] LAST_LAT  = LW'(SOFTMAX_LATENCY - 1);

  sa_seq_state_e          state_q, state_d;
  logic [TW-1:0]          tile_q, tile_d;
  logic [BW-1:0]          blk_q, blk_d;
  logic [LW-1:0]          lat_q, lat_d;
  logic                   causal_q, causal_d;
  logic                   sticky_q, sticky_d;
  logic                   en_q, en_d;
  logic [TOTAL_SOFTMAX_ROW-1:0] valid_q, valid_d;
  logic                   rst_b2r_q, rst_sm_q, rst_d;
  logic                   done_q, done_d;
  logic [PW-1:0]          thr;
  logic [PW-1:0]          gidx;

  // Next-state logic for the FSM, counters and sticky slice_done bit.
  always_comb begin
    state_d  = state_q;
    tile_d   = tile_q;
    blk_d    = blk_q;
    lat_d    = lat_q;
    causal_d = causal_q;
    sticky_d = sticky_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d  = WAIT_SLICE;
          blk_d    = '0;
          tile_d   = '0;
          lat_d    = '0;
          sticky_d = 1'b0;
          causal_d = causal_en_i;
        end
      end
      WAIT_SLICE: begin
        // slice_done is deliberately ignored until the slice starts streaming.
        if (out_ready_i) begin
          state_d = STREAM;
          tile_d  = '0;
        end
      end
      STREAM: begin
        if (slice_done_i) sticky_d = 1'b1;
        if (softmax_ready_i) begin
          if (tile_q == LAST_TILE) begin
            state_d = DRAIN;
            tile_d  = '0;
            lat_d   = '0;
          end else begin
            tile_d = tile_q + TW'(1);
          end
        end
      end
      DRAIN: begin
        if (slice_done_i) sticky_d = 1'b1;
        if (lat_q != LAST_LAT) begin
          lat_d = lat_q + LW'(1);
        end else if (sticky_q || slice_done_i) begin
          state_d = REARM;
        end
      end
      REARM: begin
        sticky_d = 1'b0;
        blk_d    = blk_q + BW'(1);
        state_d  = (blk_q == LAST_BLK) ? DONE : WAIT_SLICE;
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything, including a coincident start.
    if (abort_i) begin
      state_d  = IDLE;
      tile_d   = '0;
      blk_d    = '0;
      lat_d    = '0;
      sticky_d = 1'b0;
      causal_d = 1'b0;
    end
    en_d   = (state_d == STREAM);
    rst_d  = (state_d != REARM);
    done_d = (state_d == DONE);
  end

  // Per-row beat-valid for the upcoming cycle; rows above the diagonal are masked.
  always_comb begin
    valid_d = '0;
    thr     = PW'(tile_d) * PW'(TILE_SIZE);
    gidx    = '0;
    for (int r = 0; r < TOTAL_SOFTMAX_ROW; r++) begin
      gidx       = PW'(blk_d) * PW'(TOTAL_SOFTMAX_ROW) + PW'(r);
      valid_d[r] = en_d & ~(causal_d & (thr > gidx));
    end
  end

  // FSM state and counter registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      tile_q   <= '0;
      blk_q    <= '0;
      lat_q    <= '0;
      causal_q <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tile_q   <= tile_d;
      blk_q    <= blk_d;
      lat_q    <= lat_d;
      causal_q <= causal_d;
      sticky_q <= sticky_d;
    end
  end

  // Registered outputs, derived from the next state so they align with it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      en_q      <= 1'b0;
      valid_q   <= '0;
      rst_b2r_q <= 1'b1;
      rst_sm_q  <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      en_q      <= en_d;
      valid_q   <= valid_d;
      rst_b2r_q <= rst_d;
      rst_sm_q  <= rst_d;
      done_q    <= done_d;
    end
  end

  assign rst_n_b2r_o     = rst_b2r_q;
  assign rst_n_softmax_o = rst_sm_q;
  assign softmax_en_o    = en_q;
  assign softmax_valid_o = valid_q;
  assign head_done_o     = done_q;
  assign head_done_nxt_o = done_d;

endmodule

// File: rtl/mh_self_attention_ctrl.sv
// Multi-head self-attention controller: one independent sequencer per head
// plus a registered global done.
module mh_self_attention_ctrl
  import mh_self_attention_ctrl_pkg::*;
#(
  parameter int NUM_HEADS         = 4,
  parameter int TOTAL_SOFTMAX_ROW = DEF_TOTAL_SOFTMAX_ROW,
  parameter int COL               = DEF_COL,
  parameter int TILE_SIZE         = DEF_TILE_SIZE,
  parameter int NUM_ROW_BLOCKS    = 4,
  parameter int SOFTMAX_LATENCY   = 3
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        start,
  input  logic                                        abort,
  input  logic                                        causal_en,
  input  logic [NUM_HEADS-1:0]                        softmax_ready,
  input  logic [NUM_HEADS-1:0]                        out_ready_b2r_wrap,
  input  logic [NUM_HEADS-1:0]                        slice_done_b2r_wrap,
  output logic [NUM_HEADS-1:0]                        internal_rst_n_b2r,
  output logic [NUM_HEADS-1:0]                        internal_rst_n_softmax,
  output logic [NUM_HEADS-1:0]                        softmax_en,
  output logic [NUM_HEADS-1:0][TOTAL_SOFTMAX_ROW-1:0] softmax_valid,
  output logic [NUM_HEADS-1:0]                        head_done,
  output logic                                        all_done
);

  logic [NUM_HEADS-1:0] head_done_nxt;
  logic                 all_done_q;

  for (genvar h = 0; h < NUM_HEADS; h++) begin : g_head
    sa_head_seq #(
      .TOTAL_SOFTMAX_ROW(TOTAL_SOFTMAX_ROW),
      .COL              (COL),
      .TILE_SIZE        (TILE_SIZE),
      .NUM_ROW_BLOCKS   (NUM_ROW_BLOCKS),
      .SOFTMAX_LATENCY  (SOFTMAX_LATENCY)
    ) u_seq (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .start_i        (start),
      .abort_i        (abort),
      .causal_en_i    (causal_en),
      .softmax_ready_i(softmax_ready[h]),
      .out_ready_i    (out_ready_b2r_wrap[h]),
      .slice_done_i   (slice_done_b2r_wrap[h]),
      .rst_n_b2r_o    (internal_rst_n_b2r[h]),
      .rst_n_softmax_o(internal_rst_n_softmax[h]),
      .softmax_en_o   (softmax_en[h]),
      .softmax_valid_o(softmax_valid[h]),
      .head_done_o    (head_done[h]),
      .head_done_nxt_o(head_done_nxt[h])
    );
  end

  // Global done registered from the heads' next done values so it tracks head_done exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) all_done_q <= 1'b0;
    else        all_done_q <= &head_done_nxt;
  end

  assign all_done = all_done_q;

endmodule

// File: tb/tb_mh_self_attention_ctrl.sv
// Self-checking bench for mh_self_attention_ctrl with a transaction-level reference.
module tb_mh_self_attention_ctrl;

  localparam int NH   = 4;
  localparam int ROWS = 16;
  localparam int COL  = 64;
  localparam int TS   = 8;
  localparam int NRB  = 4;
  localparam int LAT  = 3;
  localparam int NT   = COL / TS;

  logic clk = 1'b0;
  logic rst_n, start, abort, causal_en;
  logic [NH-1:0] softmax_ready, out_ready, slice_done;
  logic [NH-1:0] rstb, rsts, softmax_en, head_done;
  logic [NH-1:0][ROWS-1:0] softmax_valid;
  logic all_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mh_self_attention_ctrl #(
    .NUM_HEADS(NH), .TOTAL_SOFTMAX_ROW(ROWS), .COL(COL), .TILE_SIZE(TS),
    .NUM_ROW_BLOCKS(NRB), .SOFTMAX_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .causal_en(causal_en),
    .softmax_ready(softmax_ready), .out_ready_b2r_wrap(out_ready),
    .slice_done_b2r_wrap(slice_done), .internal_rst_n_b2r(rstb),
    .internal_rst_n_softmax(rsts), .softmax_en(softmax_en),
    .softmax_valid(softmax_valid), .head_done(head_done), .all_done(all_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Row r of block blk is masked when the tile's first column lies beyond its global row.
  function automatic logic [ROWS-1:0] ref_valid(input bit causal, input int blk, input int tile);
    logic [ROWS-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r] = !(causal && (tile * TS > blk * ROWS + r));
    return v;
  endfunction

  // ready_mode: 0 always ready, 1 random, 2 three-cycle stall at beat 4.
  // sd_mode: 0 slice_done on first stream cycle, 1 random, 2 five cycles after drain.
  task automatic run_session(input bit causal, input int ready_mode, input int sd_mode,
                             input int skew_head, input int skew_cyc, input bit spurious,
                             input string tag);
    int phase[NH], blk[NH], beats[NH], gap[NH], offer[NH];
    int last_acc[NH], sd_cyc[NH], sd_tgt[NH], stall_left[NH];
    bit stalled[NH];
    bit fin, en_exp, exp_p, rdy, alld_exp;
    int exp_rearm;
    logic [ROWS-1:0] v_exp;
    fin = 1'b0;
    start = 1'b1; causal_en = causal;
    tick();
    start = 1'b0; causal_en = ~causal;
    for (int h = 0; h < NH; h++) begin
      phase[h] = 0; blk[h] = 0; beats[h] = 0; offer[h] = -1;
      last_acc[h] = -1; sd_cyc[h] = -1; sd_tgt[h] = 1 << 30;
      stall_left[h] = 0; stalled[h] = 1'b0;
      gap[h] = ((h == skew_head) ? skew_cyc : 0) + int'($urandom_range(0, 2));
    end
    for (int n = 0; n < 2000; n++) begin
      out_ready = '0; slice_done = '0; softmax_ready = '0;
      alld_exp = 1'b1;
      for (int h = 0; h < NH; h++) if (phase[h] != 3) alld_exp = 1'b0;
      checks++;
      if (all_done !== alld_exp) begin
        errors++;
        $display("FAIL %s all_done cyc%0d: got %b want %b", tag, cyc, all_done, alld_exp);
      end
      for (int h = 0; h < NH; h++) begin
        exp_p = 1'b0;
        if (phase[h] == 2 && sd_cyc[h] >= 0) begin
          exp_rearm = (last_acc[h] + LAT + 1 > sd_cyc[h] + 1) ? last_acc[h] + LAT + 1 : sd_cyc[h] + 1;
          exp_p = (cyc == exp_rearm);
        end
        checks++;
        if ({rstb[h], rsts[h]} !== {~exp_p, ~exp_p}) begin
          errors++;
          $display("FAIL %s rearm h%0d cyc%0d: got b2r=%b sm=%b want %b", tag, h, cyc,
                   rstb[h], rsts[h], ~exp_p);
        end
        en_exp = (phase[h] == 1 && cyc > offer[h]);
        v_exp  = en_exp ? ref_valid(causal, blk[h], beats[h]) : '0;
        checks++;
        if ({softmax_en[h], softmax_valid[h]} !== {en_exp, v_exp}) begin
          errors++;
          $display("FAIL %s beat h%0d cyc%0d blk%0d tile%0d: got en=%b v=%h want en=%b v=%h",
                   tag, h, cyc, blk[h], beats[h], softmax_en[h], softmax_valid[h], en_exp, v_exp);
        end
        checks++;
        if (head_done[h] !== (phase[h] == 3)) begin
          errors++;
          $display("FAIL %s head_done h%0d cyc%0d: got %b want %b", tag, h, cyc,
                   head_done[h], phase[h] == 3);
        end
        // slice_done once per slice, only after streaming has begun
        if (sd_cyc[h] < 0 && cyc >= sd_tgt[h] &&
            ((phase[h] == 1 && cyc > offer[h]) || phase[h] == 2)) begin
          slice_done[h] = 1'b1;
          sd_cyc[h] = cyc;
        end
        case (phase[h])
          0: begin
            softmax_ready[h] = 1'($urandom_range(0, 1));
            if (gap[h] == 0) begin
              out_ready[h] = 1'b1; offer[h] = cyc; phase[h] = 1; beats[h] = 0;
              sd_cyc[h] = -1; last_acc[h] = -1; stalled[h] = 1'b0; stall_left[h] = 0;
              sd_tgt[h] = (sd_mode == 0) ? cyc + 1 :
                          (sd_mode == 1) ? cyc + 1 + int'($urandom_range(0, 19)) : (1 << 30);
            end else begin
              if (spurious && $urandom_range(0, 1) == 1) slice_done[h] = 1'b1;
              gap[h]--;
            end
          end
          1: begin
            if (ready_mode == 0) rdy = 1'b1;
            else if (ready_mode == 1) rdy = ($urandom_range(0, 3) != 0);
            else begin
              if (en_exp && beats[h] == 4 && !stalled[h]) begin
                stalled[h] = 1'b1; stall_left[h] = 3;
              end
              rdy = (stall_left[h] == 0);
              if (stall_left[h] > 0) stall_left[h]--;
            end
            softmax_ready[h] = rdy;
            if (en_exp && rdy) begin
              beats[h]++;
              if (beats[h] == NT) begin
                phase[h] = 2; last_acc[h] = cyc;
                if (sd_mode == 2) sd_tgt[h] = cyc + LAT + 5;
              end
            end
          end
          2: begin
            softmax_ready[h] = 1'($urandom_range(0, 1));
            if (exp_p) begin
              blk[h]++;
              if (blk[h] == NRB) phase[h] = 3;
              else begin phase[h] = 0; gap[h] = int'($urandom_range(0, 2)); end
            end
          end
          default: ;
        endcase
      end
      if (alld_exp) begin fin = 1'b1; break; end
      tick();
    end
    out_ready = '0; slice_done = '0; softmax_ready = '0;
    if (!fin) begin
      checks++; errors++;
      $display("FAIL %s timeout: got unfinished heads want all done", tag);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; causal_en = 1'b0;
    softmax_ready = '0; out_ready = '0; slice_done = '0;
    tick(); tick();
    checks++;
    if (softmax_en !== '0 || softmax_valid !== '0) begin
      errors++; $display("FAIL reset en/valid: got %b/%h want 0", softmax_en, softmax_valid);
    end
    checks++;
    if (rstb !== '1 || rsts !== '1) begin
      errors++; $display("FAIL reset rst_n outs: got %b/%b want 1111", rstb, rsts);
    end
    checks++;
    if (head_done !== '0 || all_done !== 1'b0) begin
      errors++; $display("FAIL reset done: got %b/%b want 0", head_done, all_done);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();        run_session(1'b0, 0, 0, -1, 0, 1'b0, "basic");  endtask
  task automatic test_stall();        run_session(1'b0, 2, 0, -1, 0, 1'b0, "stall");  endtask
  task automatic test_causal();       run_session(1'b1, 1, 1, -1, 0, 1'b0, "causal"); endtask
  task automatic test_late_slice();   run_session(1'b1, 0, 2, -1, 0, 1'b1, "late_sd"); endtask
  task automatic test_skew();         run_session(1'b0, 1, 1, 2, 20, 1'b1, "skew");   endtask

  task automatic idle_check(input string tag);
    checks++;
    if (softmax_en !== '0 || softmax_valid !== '0 || rstb !== '1 || rsts !== '1 ||
        head_done !== '0 || all_done !== 1'b0) begin
      errors++;
      $display("FAIL %s cyc%0d: got en=%b b2r=%b sm=%b done=%b all=%b want idle outputs",
               tag, cyc, softmax_en, rstb, rsts, head_done, all_done);
    end
  endtask

  task automatic test_abort();
    // abort beats start; DONE heads drop to IDLE and ignore out_ready
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    idle_check("abort_vs_start");
    out_ready = '1;
    tick();
    out_ready = '0;
    tick();
    idle_check("idle_ignores_ready");
    // abort mid-stream
    start = 1'b1; softmax_ready = '1;
    tick();
    start = 1'b0; out_ready = '1;
    tick();
    out_ready = '0;
    tick(); tick();
    checks++;
    if (softmax_en !== '1) begin
      errors++; $display("FAIL stream_before_abort: got en=%b want 1111", softmax_en);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int i = 0; i < 10; i++) begin
      idle_check("after_abort");
      tick();
    end
    // async reset mid-drain
    start = 1'b1;
    tick();
    start = 1'b0; out_ready = '1;
    tick();
    out_ready = '0; slice_done = '1;
    tick();
    slice_done = '0;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (softmax_en !== '0) begin
      errors++; $display("FAIL drain_before_reset: got en=%b want 0000", softmax_en);
    end
    #2 rst_n = 1'b0;
    #1 idle_check("async_reset");
    for (int i = 0; i < 3; i++) begin
      tick();
      idle_check("held_reset");
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      idle_check("after_reset");
    end
    softmax_ready = '0;
    // restart must begin at block 0 (causal pattern depends on it)
    run_session(1'b1, 0, 1, -1, 0, 1'b0, "restart");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_causal();
    test_late_slice();
    test_skew();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
